// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive sampler.
// Define UART_PARITY_EN to add a parity bit to every frame.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } rx_samp_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam logic [3:0]  SAMPLE_LO  = 4'd7;
  localparam logic [3:0]  SAMPLE_MID = 4'd8;
  localparam logic [3:0]  SAMPLE_HI  = 4'd9;

  localparam int unsigned DATA_BITS = 8;

`ifdef UART_PARITY_EN
  localparam int unsigned FRAME_BITS = DATA_BITS + 3;
`else
  localparam int unsigned FRAME_BITS = DATA_BITS + 2;
`endif

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_prescaler.sv
// Oversample prescaler: one os_tick every div_q+1 clocks; divisor is latched only on load.
module uart_baud_prescaler #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             load,
  input  logic [DIV_W-1:0] divisor,
  output logic             os_tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt   <= '0;
      div_q <= '0;
    end else begin
      if (load) begin
        div_q <= divisor;
      end
      if (clr || cnt == div_q) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

  assign os_tick = !clr && (cnt == div_q);

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: synchronizer, start-edge detect, 16x oversampling with 3-sample vote.
// Frame length follows UART_PARITY_EN (10 bits without, 11 with).
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] divisor,
  output logic             data_o,
  output logic             baud_tick,
  output logic             busy,
  output logic             false_start
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  logic           sync1;
  logic           rx_s;
  logic           rx_q;
  logic [1:0]     settle;
  rx_samp_state_t state;
  logic [3:0]     os_cnt;
  logic [3:0]     bit_cnt;
  logic [1:0]     samp;
  logic           os_tick;
  logic           start_edge;
  logic           pre_clr;
  logic           vote;

  // The chain resets high, so an edge is only trusted once real line values
  // have reached rx_q; a line held low across reset release never starts a frame.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1  <= 1'b1;
      rx_s   <= 1'b1;
      rx_q   <= 1'b1;
      settle <= '0;
    end else begin
      sync1 <= rx_i;
      rx_s  <= sync1;
      rx_q  <= rx_s;
      if (settle != 2'd3) begin
        settle <= settle + 2'd1;
      end
    end
  end

  assign start_edge = (state == IDLE) && en && (settle == 2'd3) && rx_q && !rx_s;
  assign pre_clr    = (state == IDLE) || !en;
  assign vote       = majority3(samp[0], samp[1], rx_s);

  uart_baud_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (pre_clr),
    .load   (start_edge),
    .divisor(divisor),
    .os_tick(os_tick)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      os_cnt      <= '0;
      bit_cnt     <= '0;
      samp        <= '1;
      data_o      <= 1'b1;
      baud_tick   <= 1'b0;
      busy        <= 1'b0;
      false_start <= 1'b0;
    end else begin
      baud_tick   <= 1'b0;
      false_start <= 1'b0;
      if (!en) begin
        state   <= IDLE;
        os_cnt  <= '0;
        bit_cnt <= '0;
        samp    <= '1;
        data_o  <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            data_o <= rx_s;
            if (start_edge) begin
              state   <= START;
              os_cnt  <= '0;
              bit_cnt <= '0;
              busy    <= 1'b1;
            end
          end
          START, RUN: begin
            if (os_tick) begin
              os_cnt <= os_cnt + 4'd1;
              if (os_cnt == SAMPLE_LO) begin
                samp[0] <= rx_s;
              end
              if (os_cnt == SAMPLE_MID) begin
                samp[1] <= rx_s;
              end
              // Third sample is the live rx_s, voted in the same cycle it is taken.
              if (os_cnt == SAMPLE_HI) begin
                baud_tick <= 1'b1;
                data_o    <= vote;
                if (state == START) begin
                  if (vote) begin
                    false_start <= 1'b1;
                    state       <= IDLE;
                    busy        <= 1'b0;
                  end else begin
                    state   <= RUN;
                    bit_cnt <= 4'd1;
                  end
                end else begin
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == LAST_BIT) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                  end
                end
              end
            end
          end
          default: begin
            state  <= IDLE;
            data_o <= 1'b1;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: stimulus queues expected ticks, a monitor checks them.
// Frame length follows UART_PARITY_EN, as in the design.
module tb_uart_rx_sampler;

  localparam int unsigned NB = uart_pkg::FRAME_BITS;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en;
  logic        rx_i;
  logic [15:0] divisor;
  logic        data_o;
  logic        baud_tick;
  logic        busy;
  logic        false_start;

  uart_rx_sampler #(
    .DIV_W(16)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .en         (en),
    .rx_i       (rx_i),
    .divisor    (divisor),
    .data_o     (data_o),
    .baud_tick  (baud_tick),
    .busy       (busy),
    .false_start(false_start)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    logic        data;
    logic        fs;
    logic        busy_chk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  logic prev_tick = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_tick(input int unsigned at, input logic data, input logic fs,
                             input logic busy_chk);
    exp_t e;
    e.at = at;
    e.data = data;
    e.fs = fs;
    e.busy_chk = busy_chk;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (baud_tick === 1'b1) begin
      check("tick_not_consecutive", {31'd0, prev_tick}, 32'd0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_tick at cycle %0d: got baud_tick=1 data_o=%b, expected no tick",
                 cyc, data_o);
      end else begin
        mon_e = sb.pop_front();
        check("tick_cycle", cyc, mon_e.at);
        check("tick_data", {31'd0, data_o}, {31'd0, mon_e.data});
        check("tick_false_start", {31'd0, false_start}, {31'd0, mon_e.fs});
        if (mon_e.busy_chk) check("tick_busy", {31'd0, busy}, 32'd1);
      end
    end else if (false_start === 1'b1) begin
      check("false_start_without_tick", {31'd0, false_start}, 32'd0);
    end
    prev_tick = baud_tick;
  end

  // Drives one frame; expected tick n is 3 + 10*(d+1) + n*16*(d+1) cycles after the start drive.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic glitch,
                            input int unsigned div_at_bit, input logic [15:0] new_div);
    logic [10:0] bits;
    int unsigned per;
    int unsigned first;
    int unsigned n0;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = data;
    if (NB == 11) bits[9] = par;
    per = 16 * (int'(divisor) + 1);
    first = 10 * (int'(divisor) + 1);
    @(negedge clk);
    n0 = cyc;
    for (int k = 0; k < NB; k++) begin
      expect_tick(n0 + 3 + first + per * k, bits[k], 1'b0, (k < NB - 1));
    end
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < per; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        rx_i = bits[b] ^ (glitch && b == 1 && c == 36);
        if (div_at_bit != 0 && b == div_at_bit && c == 0) divisor = new_div;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout at cycle %0d: got no completion, expected summary", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n0;
    nrst = 1'b0;
    en = 1'b1;
    rx_i = 1'b1;
    divisor = 16'd3;
    idle_cycles(3);
    check("reset_data_o", {31'd0, data_o}, 32'd1);
    check("reset_baud_tick", {31'd0, baud_tick}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_false_start", {31'd0, false_start}, 32'd0);
    nrst = 1'b1;
    idle_cycles(10);

    // 0x55 at divisor 3
    send_frame(8'h55, 1'b0, 1'b0, 0, 16'd0);
    idle_cycles(5);
    check("busy_after_0x55", {31'd0, busy}, 32'd0);
    check("drained_0x55", sb.size(), 0);
    idle_cycles(10);

    // false start: line low for only 8 clocks
    @(negedge clk);
    n0 = cyc;
    rx_i = 1'b0;
    expect_tick(n0 + 43, 1'b1, 1'b1, 1'b0);
    idle_cycles(8);
    rx_i = 1'b1;
    idle_cycles(200);
    check("busy_after_false_start", {31'd0, busy}, 32'd0);
    check("drained_false_start", sb.size(), 0);

    // one-clock glitch on sample 8 of data bit 0
    send_frame(8'h54, 1'b0, 1'b1, 0, 16'd0);
    idle_cycles(5);
    check("drained_glitch", sb.size(), 0);
    idle_cycles(10);

    // back-to-back frames, no idle gap
    send_frame(8'hA3, 1'b0, 1'b0, 0, 16'd0);
    send_frame(8'h3C, 1'b0, 1'b0, 0, 16'd0);
    idle_cycles(5);
    check("drained_back_to_back", sb.size(), 0);
    idle_cycles(10);

    // divisor changed to 7 mid-frame: spacing stays 64 this frame, 128 on the next
    send_frame(8'h0F, 1'b0, 1'b0, 3, 16'd7);
    idle_cycles(5);
    check("drained_div_change", sb.size(), 0);
    idle_cycles(10);
    send_frame(8'hC5, 1'b1, 1'b0, 0, 16'd0);
    idle_cycles(5);
    check("drained_div7", sb.size(), 0);
    divisor = 16'd0;
    idle_cycles(10);
    send_frame(8'h96, 1'b0, 1'b0, 0, 16'd0);
    idle_cycles(5);
    check("drained_div0", sb.size(), 0);
    divisor = 16'd3;
    idle_cycles(10);

    // en dropped mid start bit
    @(negedge clk);
    rx_i = 1'b0;
    idle_cycles(20);
    check("busy_before_en_low", {31'd0, busy}, 32'd1);
    en = 1'b0;
    idle_cycles(1);
    check("en_low_busy", {31'd0, busy}, 32'd0);
    check("en_low_data_o", {31'd0, data_o}, 32'd1);
    rx_i = 1'b1;
    idle_cycles(5);
    en = 1'b1;
    idle_cycles(100);
    check("en_low_no_restart", {31'd0, busy}, 32'd0);

    // reset mid-frame with line held low across release
    @(negedge clk);
    n0 = cyc;
    rx_i = 1'b0;
    expect_tick(n0 + 43, 1'b0, 1'b0, 1'b1);
    idle_cycles(60);
    check("busy_before_reset", {31'd0, busy}, 32'd1);
    nrst = 1'b0;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_data_o", {31'd0, data_o}, 32'd1);
    check("midreset_baud_tick", {31'd0, baud_tick}, 32'd0);
    check("midreset_false_start", {31'd0, false_start}, 32'd0);
    idle_cycles(2);
    nrst = 1'b1;
    idle_cycles(20);
    check("no_start_low_line_after_reset", {31'd0, busy}, 32'd0);
    rx_i = 1'b1;
    idle_cycles(20);
    send_frame(8'h81, 1'b0, 1'b0, 0, 16'd0);
    idle_cycles(5);
    check("drained_final", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Front end of the UART receive path: synchronizes the asynchronous serial line, detects the start-bit falling edge, and 16x-oversamples each bit. It drives `baud_tick` and a majority-voted `data_o` straight into `receiver_FSM` (`baud_tick`, `data_i`). It emits exactly one tick per frame bit (start, data, optional parity, stop), centred on the bit, then re-arms for the next start edge.

## Interface
Parameters:
- `DIV_W`, 16, width of the oversample divisor.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `nrst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  sampler enable. Low forces IDLE synchronously.
- `rx_i`  in  1  raw serial line, asynchronous to `clk`, idle high.
- `divisor`  in  DIV_W  clocks per oversample tick minus 1.
- `data_o`  out  1  filtered line value; feeds `receiver_FSM.data_i`.
- `baud_tick`  out  1  one-cycle pulse at bit centre; feeds `receiver_FSM.baud_tick`.
- `busy`  out  1  high while a frame is being sampled.
- `false_start`  out  1  one-cycle pulse when the start bit fails its centre vote.

## Operation
- Synchronizer: 2-flop chain on `rx_i`. Both flops reset to 1. `rx_s` is the second flop; `rx_q` is `rx_s` delayed by one cycle.
- Prescaler: counts 0..`div_q` and pulses `os_tick` when count == `div_q`. `div_q` is loaded from `divisor` only on IDLE→START, so a divisor change mid-frame has no effect until the next frame. Divisor 0 gives `os_tick` on every clock.
- Oversample counter `os_cnt` is 4 bits and counts `os_tick`s 0..15, wrapping. Samples are taken at `os_cnt` 7, 8 and 9 into `s[2:0]`. The vote is the majority of the three.
- Bit counter `bit_cnt` is 4 bits and counts bits already ticked. `FRAME_BITS` is 10 (start, 8 data, stop), or 11 with parity configured.
- States:
  - IDLE: `data_o` <= `rx_s`. A falling edge (`rx_q`=1, `rx_s`=0) with `en`=1 moves to START and clears the prescaler, `os_cnt` and `bit_cnt`.
  - START: on the `os_tick` at `os_cnt`=9, `baud_tick` <= 1 and `data_o` <= vote.
    - Vote 0: go to RUN with `bit_cnt`=1.
    - Vote 1: pulse `false_start` and go to IDLE. The tick with `data_o`=1 returns `receiver_FSM` to its IDLE.
  - RUN: on each `os_tick` at `os_cnt`=9, `baud_tick` <= 1, `data_o` <= vote and `bit_cnt`++. When the ticked bit is the last one (`bit_cnt` == `FRAME_BITS`-1 before the increment), go to IDLE. This is mid stop bit, so back-to-back frames are accepted.
- `busy` = (state != IDLE), registered.
- `en` low in any state: next cycle state=IDLE, counters are cleared, and outputs take their reset values.
- Illegal state encoding goes to IDLE.
- `nrst` low mid-frame: everything returns to reset values immediately. After release, the line must be seen high and then falling before a new frame starts.

## Timing
- Reset values: `data_o`=1, `baud_tick`=0, `busy`=0, `false_start`=0, state=IDLE.
- All outputs are registered. `baud_tick` and the updated `data_o` appear in the same cycle, so the consumer samples `data_o` while `baud_tick`=1.
- `rx_i` to `rx_s` latency: 2 cycles. Falling edge in `rx_s` to START: 1 cycle.
- START entry to the first `baud_tick`: 10·(`div_q`+1) cycles. Successive ticks are 16·(`div_q`+1) cycles apart.
- `baud_tick` is never high on two consecutive cycles. `false_start` coincides with its `baud_tick`.

## Configuration
- `UART_PARITY_EN` defined: `FRAME_BITS`=11, i.e. 11 ticks per frame including the parity bit.
- Not defined: `FRAME_BITS`=10. Must match the `receiver_FSM` build.

## Structure
- `uart_pkg` holds:
  - the state enum `rx_samp_state_t` (IDLE, START, RUN);
  - `OVERSAMPLE`=16, `SAMPLE_LO`=7, `SAMPLE_MID`=8, `SAMPLE_HI`=9;
  - `DATA_BITS`=8;
  - `FRAME_BITS`, selected by `UART_PARITY_EN`.
- One sub-module, `uart_baud_prescaler`: inputs `clk`, `nrst`, `clr`, `load`, `divisor`; output `os_tick`. The synchronizer, FSM and voter stay in the top.

## Test plan
- Reset with `rx_i`=1: `data_o`=1, `baud_tick`=0, `busy`=0. Pulse `nrst` mid-frame: all outputs return to reset values within 1 cycle.
- `divisor`=3, frame 0x55 LSB-first, no parity: 10 ticks, 64 cycles apart, the first 40 cycles after START entry. `data_o` at ticks reads 0,1,0,1,0,1,0,1,0,1. `busy` drops after tick 10.
- `divisor`=3, `rx_i` low for 8 clocks only: one `baud_tick` with `data_o`=1, `false_start`=1, back to IDLE, no further ticks.
- `divisor`=3, a 1-clock glitch high on sample 8 of data bit 0 (value 0): vote still 0.
- Two frames back-to-back (0xA3, then 0x3C with no idle gap): 20 ticks total, the second start detected on its edge.
- `UART_PARITY_EN` build, frame 0x0F with parity bit 0: 11 ticks, tick 10 `data_o`=0, tick 11 `data_o`=1. Changing `divisor` to 7 mid-frame leaves the tick spacing at 64 until the next frame.
